// File: rtl/nn_inference_sequencer.sv
// nn_inference_sequencer: walks one inference pass through a chain of layer
// stages (dense layers, then select_max), one stage enabled at a time, pulses
// each stage's clear after its done, captures the final digit/max and offers
// the result to the host over a valid/ready handshake.
// Optional per-stage watchdog: define NN_SEQ_TIMEOUT_EN.
module nn_inference_sequencer #(
    parameter int unsigned NUM_LAYERS     = 3,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned DIGIT_W        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned StageW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [NUM_LAYERS-1:0] layer_en_o,
    output logic [NUM_LAYERS-1:0] layer_clr_o,
    input  logic [NUM_LAYERS-1:0] layer_done_i,
    input  logic [DIGIT_W-1:0]    final_digit_i,
    input  logic [DATA_W-1:0]     final_max_i,
    output logic [DIGIT_W-1:0]    result_digit_o,
    output logic [DATA_W-1:0]     result_max_o,
    output logic [31:0]           result_cycles_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic                  busy_o,
    output logic [StageW-1:0]     stage_idx_o,
    output logic                  error_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StClear  = 2'd2;
    localparam logic [1:0] StResult = 2'd3;

    localparam logic [NUM_LAYERS-1:0] OneLsb   = NUM_LAYERS'(1);
    localparam logic [StageW-1:0]     LastIdx  = StageW'(NUM_LAYERS - 1);

    logic [1:0]            state_q, state_d;
    logic [StageW-1:0]     stage_q, stage_d;
    logic [NUM_LAYERS-1:0] en_q, en_d;
    logic [NUM_LAYERS-1:0] clr_q, clr_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic [DIGIT_W-1:0]    digit_q, digit_d;
    logic [DATA_W-1:0]     max_q, max_d;
    logic [31:0]           cycles_q, cycles_d;
    logic [31:0]           res_cycles_q, res_cycles_d;
    logic [31:0]           cycles_inc;
    logic                  last_stage;
    logic                  cur_done;
`ifdef NN_SEQ_TIMEOUT_EN
    logic                  err_q, err_d;
    logic [31:0]           wdog_q, wdog_d;
`endif

    assign last_stage = (stage_q == LastIdx);
    assign cur_done   = layer_done_i[stage_q];
    // Pass-length counter saturates rather than wrapping.
    assign cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        en_d         = en_q;
        clr_d        = '0;
        valid_d      = valid_q;
        digit_d      = digit_q;
        max_d        = max_q;
        cycles_d     = cycles_q;
        res_cycles_d = res_cycles_q;
`ifdef NN_SEQ_TIMEOUT_EN
        err_d        = err_q;
        wdog_d       = wdog_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StRun;
                    stage_d  = '0;
                    en_d     = OneLsb;
                    cycles_d = '0;
`ifdef NN_SEQ_TIMEOUT_EN
                    err_d    = 1'b0;
                    wdog_d   = '0;
`endif
                end
            end
            StRun: begin
                cycles_d = cycles_inc;
                if (cur_done) begin
                    state_d = StClear;
                    en_d    = '0;
                    clr_d   = OneLsb << stage_q;
                    if (last_stage) begin
                        digit_d = final_digit_i;
                        max_d   = final_max_i;
                    end
                end
`ifdef NN_SEQ_TIMEOUT_EN
                else if (wdog_q == TIMEOUT_CYCLES - 1) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                    stage_d = '0;
                    en_d    = '0;
                    clr_d   = '1;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
`endif
            end
            StClear: begin
                cycles_d = cycles_inc;
                if (last_stage) begin
                    state_d      = StResult;
                    valid_d      = 1'b1;
                    res_cycles_d = cycles_inc;
                end else begin
                    state_d = StRun;
                    stage_d = stage_q + StageW'(1);
                    en_d    = OneLsb << (stage_q + StageW'(1));
`ifdef NN_SEQ_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            default: begin
                if (result_ready_i) begin
                    state_d = StIdle;
                    stage_d = '0;
                    valid_d = 1'b0;
                end
            end
        endcase
        // Abort overrides everything decided above; captured results survive.
        if (abort_i && (state_q != StIdle)) begin
            state_d      = StIdle;
            stage_d      = '0;
            en_d         = '0;
            clr_d        = '1;
            valid_d      = 1'b0;
            digit_d      = digit_q;
            max_d        = max_q;
            res_cycles_d = res_cycles_q;
`ifdef NN_SEQ_TIMEOUT_EN
            err_d        = err_q;
`endif
        end
        busy_d = (state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            stage_q      <= '0;
            en_q         <= '0;
            clr_q        <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            digit_q      <= '0;
            max_q        <= '0;
            cycles_q     <= '0;
            res_cycles_q <= '0;
`ifdef NN_SEQ_TIMEOUT_EN
            err_q        <= 1'b0;
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            en_q         <= en_d;
            clr_q        <= clr_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            digit_q      <= digit_d;
            max_q        <= max_d;
            cycles_q     <= cycles_d;
            res_cycles_q <= res_cycles_d;
`ifdef NN_SEQ_TIMEOUT_EN
            err_q        <= err_d;
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign layer_en_o      = en_q;
    assign layer_clr_o     = clr_q;
    assign result_digit_o  = digit_q;
    assign result_max_o    = max_q;
    assign result_cycles_o = res_cycles_q;
    assign result_valid_o  = valid_q;
    assign busy_o          = busy_q;
    assign stage_idx_o     = stage_q;
`ifdef NN_SEQ_TIMEOUT_EN
    assign error_o         = err_q;
`else
    assign error_o         = 1'b0;
`endif

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Directed bench for nn_inference_sequencer: table of full passes plus
// hand-written reset, backpressure, stray-done, abort and watchdog sequences.
module tb_nn_inference_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        result_ready = 1'b0;
    logic [2:0]  layer_done = 3'b000;
    logic [7:0]  final_digit = 8'h00;
    logic [15:0] final_max = 16'h0000;

    logic [2:0]  layer_en;
    logic [2:0]  layer_clr;
    logic [7:0]  result_digit;
    logic [15:0] result_max;
    logic [31:0] result_cycles;
    logic        result_valid;
    logic        busy;
    logic [1:0]  stage_idx;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int unsigned d0;
        int unsigned d1;
        int unsigned d2;
        logic [7:0]  digit;
        logic [15:0] maxv;
        logic [31:0] cycles;
    } vec_t;

    vec_t vecs[4];

    nn_inference_sequencer #(
        .NUM_LAYERS    (3),
        .DATA_W        (16),
        .DIGIT_W       (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .layer_en_o     (layer_en),
        .layer_clr_o    (layer_clr),
        .layer_done_i   (layer_done),
        .final_digit_i  (final_digit),
        .final_max_i    (final_max),
        .result_digit_o (result_digit),
        .result_max_o   (result_max),
        .result_cycles_o(result_cycles),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready),
        .busy_o         (busy),
        .stage_idx_o    (stage_idx),
        .error_o        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs one stage from just after its RUN entry; done seen on the d-th edge.
    task automatic run_stage(input int s, input int unsigned d, input vec_t v);
        logic [2:0] one;
        one = 3'b001;
        check("stage_idx", 64'(stage_idx), 64'(s));
        check("en_onehot", 64'(layer_en), 64'(one << s));
        check("clr_idle", 64'(layer_clr), 64'h0);
        for (int unsigned k = 1; k < d; k++) tick();
        check("en_held", 64'(layer_en), 64'(one << s));
        if (s == 2) begin
            final_digit = v.digit;
            final_max   = v.maxv;
        end
        layer_done = one << s;
        tick();
        layer_done  = 3'b000;
        final_digit = 8'hEE;
        final_max   = 16'h1234;
        check("clr_pulse", 64'(layer_clr), 64'(one << s));
        check("en_off_clear", 64'(layer_en), 64'h0);
        tick();
        check("clr_one_cycle", 64'(layer_clr), 64'h0);
    endtask

    // Full pass from IDLE up to RESULT; handshake left to the caller.
    task automatic run_pass(input vec_t v);
        pulse_start();
        check("busy_run", 64'(busy), 64'h1);
        run_stage(0, v.d0, v);
        run_stage(1, v.d1, v);
        run_stage(2, v.d2, v);
        check("valid", 64'(result_valid), 64'h1);
        check("busy_result", 64'(busy), 64'h1);
        check("res_digit", 64'(result_digit), 64'(v.digit));
        check("res_max", 64'(result_max), 64'(v.maxv));
        check("res_cycles", 64'(result_cycles), 64'(v.cycles));
    endtask

    initial begin
        // cycles = sum of RUN cycles + one CLEAR cycle per stage
        vecs[0] = '{d0: 5, d1: 7,  d2: 3, digit: 8'd3, maxv: 16'd85,    cycles: 32'd18};
        vecs[1] = '{d0: 1, d1: 1,  d2: 1, digit: 8'd9, maxv: 16'hFFFB,  cycles: 32'd6};
        vecs[2] = '{d0: 2, d1: 10, d2: 4, digit: 8'd0, maxv: 16'h8000,  cycles: 32'd19};
        vecs[3] = '{d0: 3, d1: 1,  d2: 6, digit: 8'd7, maxv: 16'h7FFF,  cycles: 32'd13};

        // Reset state
        #12;
        check("rst_en", 64'(layer_en), 64'h0);
        check("rst_clr", 64'(layer_clr), 64'h0);
        check("rst_valid", 64'(result_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_cycles", 64'(result_cycles), 64'h0);
        check("rst_error", 64'(error), 64'h0);
        rst_n = 1'b1;
        tick();

        // Nominal passes, ready held high
        result_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_pass(vecs[i]);
            tick();
            check("valid_one_cycle", 64'(result_valid), 64'h0);
            check("idle_after_ready", 64'(busy), 64'h0);
            check("digit_retained", 64'(result_digit), 64'(vecs[i].digit));
        end

        // Asynchronous reset in the middle of stage 0
        pulse_start();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_en", 64'(layer_en), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_digit", 64'(result_digit), 64'h0);
        check("arst_stage", 64'(stage_idx), 64'h0);
        #3 rst_n = 1'b1;
        tick();
        run_pass(vecs[0]);
        tick();
        check("post_rst_idle", 64'(busy), 64'h0);

        // Backpressure: result held, start ignored, start with ready dropped
        result_ready = 1'b0;
        run_pass(vecs[1]);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            tick();
            check("bp_valid", 64'(result_valid), 64'h1);
            check("bp_digit", 64'(result_digit), 64'(vecs[1].digit));
            check("bp_max", 64'(result_max), 64'(vecs[1].maxv));
        end
        start = 1'b1;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        check("bp_done_valid", 64'(result_valid), 64'h0);
        check("bp_start_dropped", 64'(busy), 64'h0);
        tick();
        check("bp_still_idle", 64'(layer_en), 64'h0);

        // Stray dones, and a done held across CLEAR
        result_ready = 1'b0;
        pulse_start();
        layer_done = 3'b100;
        repeat (3) tick();
        check("stray_en", 64'(layer_en), 64'h1);
        check("stray_stage", 64'(stage_idx), 64'h0);
        layer_done = 3'b101;
        tick();
        check("stray_clr0", 64'(layer_clr), 64'h1);
        tick();
        check("held_en1", 64'(layer_en), 64'h2);
        tick();
        check("held_no_skip", 64'(layer_en), 64'h2);
        check("held_stage1", 64'(stage_idx), 64'h1);
        layer_done = 3'b010;
        tick();
        check("stray_clr1", 64'(layer_clr), 64'h2);
        layer_done = 3'b000;
        tick();
        check("stray_en2", 64'(layer_en), 64'h4);
        final_digit = 8'd5;
        final_max   = 16'hFFFF;
        layer_done  = 3'b100;
        tick();
        layer_done = 3'b000;
        tick();
        check("stray_valid", 64'(result_valid), 64'h1);
        check("stray_cycles", 64'(result_cycles), 64'd10);
        check("stray_digit", 64'(result_digit), 64'd5);
        result_ready = 1'b1;
        tick();
        check("stray_idle", 64'(busy), 64'h0);

        // Abort in stage 1 together with its done
        result_ready = 1'b0;
        pulse_start();
        layer_done = 3'b001;
        tick();
        layer_done = 3'b000;
        tick();
        tick();
        check("ab_stage1", 64'(layer_en), 64'h2);
        abort = 1'b1;
        layer_done = 3'b010;
        tick();
        abort = 1'b0;
        layer_done = 3'b000;
        check("ab_clr_all", 64'(layer_clr), 64'h7);
        check("ab_en_off", 64'(layer_en), 64'h0);
        check("ab_idle", 64'(busy), 64'h0);
        check("ab_valid", 64'(result_valid), 64'h0);
        check("ab_digit_kept", 64'(result_digit), 64'd5);
        tick();
        check("ab_clr_one_cycle", 64'(layer_clr), 64'h0);
        // Abort in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_idle_noclr", 64'(layer_clr), 64'h0);
        // Abort wins over ready in RESULT
        run_pass(vecs[3]);
        abort = 1'b1;
        result_ready = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_res_clr", 64'(layer_clr), 64'h7);
        check("ab_res_valid", 64'(result_valid), 64'h0);
        check("ab_res_kept", 64'(result_max), 64'(vecs[3].maxv));

        // Watchdog
        result_ready = 1'b0;
        pulse_start();
`ifdef NN_SEQ_TIMEOUT_EN
        repeat (15) tick();
        check("wd_not_yet", 64'(error), 64'h0);
        check("wd_en_held", 64'(layer_en), 64'h1);
        tick();
        check("wd_error", 64'(error), 64'h1);
        check("wd_clr_all", 64'(layer_clr), 64'h7);
        check("wd_idle", 64'(busy), 64'h0);
        tick();
        check("wd_sticky", 64'(error), 64'h1);
        check("wd_clr_one_cycle", 64'(layer_clr), 64'h0);
        pulse_start();
        check("wd_cleared", 64'(error), 64'h0);
`else
        repeat (40) tick();
        check("nowd_error", 64'(error), 64'h0);
        check("nowd_waits", 64'(layer_en), 64'h1);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("final_idle", 64'(busy), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
